// File: rtl/uart_pkg.sv
// ----------------------------------------------------------------------------
// uart_pkg
// Shared UART definitions used by the configurable receiver (and by the
// sibling transmitter for the parity mode).
//   parity_e        : line parity mode (none / even / odd)
//   rx_state_e      : receiver frame FSM states
//   MAX_DATA_BITS   : widest payload supported by the parity helper
//   maj3()          : 2-of-3 majority used for the per-bit sample vote
//   expected_parity(): parity bit a transmitter would send for a payload
// ----------------------------------------------------------------------------
package uart_pkg;

    typedef enum logic [1:0] {
        ParityNone = 2'd0,
        ParityEven = 2'd1,
        ParityOdd  = 2'd2
    } parity_e;

    typedef enum logic [2:0] {
        RX_IDLE      = 3'd0,
        RX_START     = 3'd1,
        RX_DATA      = 3'd2,
        RX_PARITY    = 3'd3,
        RX_STOP      = 3'd4,
        RX_WAIT_HIGH = 3'd5
    } rx_state_e;

    localparam int MAX_DATA_BITS = 9;

    // Majority of three samples.
    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

    // Parity bit expected on the line for a zero-extended payload.
    function automatic logic expected_parity(input logic [MAX_DATA_BITS-1:0] payload,
                                             input parity_e                  mode);
        logic par_s;
        case (mode)
            ParityEven: par_s = ^payload;
            ParityOdd:  par_s = ~(^payload);
            default:    par_s = 1'b0;
        endcase
        return par_s;
    endfunction

endpackage

// File: rtl/uart_rx_cfg_sync_2ff.sv
// ----------------------------------------------------------------------------
// sync_2ff
// Two-flop synchronizer for an asynchronous, idle-high serial line.
// Both flops reset to 1 so that a reset never looks like a start bit.
//   clk   in  system clock
//   rst_n in  asynchronous active-low reset
//   d     in  asynchronous input
//   q     out synchronized copy of d, two clk later
// ----------------------------------------------------------------------------
module sync_2ff (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic [1:0] sync_r;

    // Shift the raw line through two flops; reset to the idle-high level.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_r <= 2'b11;
        end else begin
            sync_r <= {sync_r[0], d};
        end
    end

    assign q = sync_r[1];

endmodule

// File: rtl/uart_rx_cfg.sv
// ----------------------------------------------------------------------------
// uart_rx_cfg
// Oversampling UART receiver with configurable payload width, parity mode,
// stop-bit count and oversampling ratio. Each bit is decided by a 2-of-3
// vote over the samples around the bit centre. Framing and parity errors are
// reported as separate one-clk pulses; a discarded frame never touches data.
//
// Parameters
//   DataBits   payload bits per frame (5..9), LSB first on the line
//   Oversample sample_trigger strobes per bit period (even, >= 4)
//   Parity     uart_pkg::parity_e
//   StopBits   1 or 2
// Ports
//   clk            in  system clock
//   rst_n          in  asynchronous active-low reset
//   sample_trigger in  one-clk strobe, Oversample per bit period
//   raw_data       in  asynchronous serial line, idle high
//   data           out last good payload, held until the next good frame
//   data_valid     out one-clk pulse, data is new
//   parity_error   out one-clk pulse, parity mismatch, frame discarded
//   framing_error  out one-clk pulse, a stop bit sampled low, frame discarded
// ----------------------------------------------------------------------------
module uart_rx_cfg
    import uart_pkg::*;
#(
    parameter int      DataBits   = 8,
    parameter int      Oversample = 16,
    parameter parity_e Parity     = ParityNone,
    parameter int      StopBits   = 1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                sample_trigger,
    input  logic                raw_data,
    output logic [DataBits-1:0] data,
    output logic                data_valid,
    output logic                parity_error,
    output logic                framing_error
);

    localparam int SAMP_W = $clog2(Oversample);
    localparam int BIT_W  = $clog2(DataBits + StopBits + 1);
    localparam int C      = Oversample / 2;

    localparam logic [SAMP_W-1:0] SAMP_ZERO   = SAMP_W'(0);
    localparam logic [SAMP_W-1:0] SAMP_ONE    = SAMP_W'(1);
    localparam logic [SAMP_W-1:0] SAMP_VOTE_A = SAMP_W'(C - 1);
    localparam logic [SAMP_W-1:0] SAMP_VOTE_B = SAMP_W'(C);
    localparam logic [SAMP_W-1:0] SAMP_DECIDE = SAMP_W'(C + 1);
    localparam logic [SAMP_W-1:0] SAMP_LAST   = SAMP_W'(Oversample - 1);

    localparam logic [BIT_W-1:0] BIT_ZERO      = BIT_W'(0);
    localparam logic [BIT_W-1:0] BIT_ONE       = BIT_W'(1);
    localparam logic [BIT_W-1:0] BIT_DATA_LAST = BIT_W'(DataBits - 1);
    // bit_cnt keeps counting through the stop bits after the payload.
    localparam logic [BIT_W-1:0] BIT_STOP_LAST = BIT_W'(DataBits + StopBits - 1);

    localparam bit HAS_PARITY = (Parity != ParityNone);

    // Synchronized serial line; nothing below looks at raw_data directly.
    logic line_s;

    rx_state_e           state_r,    state_nxt_s;
    logic [SAMP_W-1:0]   samp_cnt_r, samp_nxt_s;
    logic [BIT_W-1:0]    bit_cnt_r,  bit_nxt_s;
    logic [DataBits-1:0] shift_r,    shift_nxt_s;
    logic [1:0]          vote_r,     vote_nxt_s;     // samples C-1 and C
    logic                par_err_r,  par_err_nxt_s;  // latched until stop decision
    logic                stop_err_r, stop_err_nxt_s; // any earlier stop bit low
    logic [DataBits-1:0] data_r,     data_nxt_s;
    logic                valid_r,    valid_nxt_s;
    logic                perr_r,     perr_nxt_s;
    logic                ferr_r,     ferr_nxt_s;

    logic                samp_last_s;
    logic                decide_s;
    logic [SAMP_W-1:0]   samp_inc_s;
    logic                bit_val_s;
    logic                par_exp_s;

    sync_2ff u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (raw_data),
        .q     (line_s)
    );

    assign samp_last_s = (samp_cnt_r == SAMP_LAST);
    assign decide_s    = (samp_cnt_r == SAMP_DECIDE);
    assign samp_inc_s  = samp_last_s ? SAMP_ZERO : (samp_cnt_r + SAMP_ONE);
    // The third vote sample is the one arriving at the decision point.
    assign bit_val_s   = maj3(vote_r[0], vote_r[1], line_s);
    assign par_exp_s   = expected_parity(MAX_DATA_BITS'(shift_r), Parity);

    // Next-state, counter, datapath and output-pulse decode.
    always_comb begin
        state_nxt_s    = state_r;
        samp_nxt_s     = samp_cnt_r;
        bit_nxt_s      = bit_cnt_r;
        shift_nxt_s    = shift_r;
        vote_nxt_s     = vote_r;
        par_err_nxt_s  = par_err_r;
        stop_err_nxt_s = stop_err_r;
        data_nxt_s     = data_r;
        valid_nxt_s    = 1'b0;
        perr_nxt_s     = 1'b0;
        ferr_nxt_s     = 1'b0;

        if (sample_trigger) begin
            // Capture the two leading vote samples; harmless outside bit
            // states because samp_cnt stays 0 there and C-1 >= 1.
            if (samp_cnt_r == SAMP_VOTE_A) begin
                vote_nxt_s[0] = line_s;
            end else if (samp_cnt_r == SAMP_VOTE_B) begin
                vote_nxt_s[1] = line_s;
            end else begin
                vote_nxt_s = vote_r;
            end

            case (state_r)
                RX_IDLE: begin
                    samp_nxt_s = SAMP_ZERO;
                    if (!line_s) begin
                        // This low sample is index 0 of the start bit.
                        state_nxt_s    = RX_START;
                        samp_nxt_s     = SAMP_ONE;
                        bit_nxt_s      = BIT_ZERO;
                        par_err_nxt_s  = 1'b0;
                        stop_err_nxt_s = 1'b0;
                    end else begin
                        state_nxt_s = RX_IDLE;
                    end
                end

                RX_START: begin
                    samp_nxt_s = samp_inc_s;
                    if (decide_s && bit_val_s) begin
                        // Glitch, not a start bit: drop it silently.
                        state_nxt_s = RX_IDLE;
                        samp_nxt_s  = SAMP_ZERO;
                    end else if (samp_last_s) begin
                        state_nxt_s = RX_DATA;
                    end else begin
                        state_nxt_s = RX_START;
                    end
                end

                RX_DATA: begin
                    samp_nxt_s = samp_inc_s;
                    if (decide_s) begin
                        shift_nxt_s = {bit_val_s, shift_r[DataBits-1:1]};
                    end else begin
                        shift_nxt_s = shift_r;
                    end
                    if (samp_last_s) begin
                        bit_nxt_s = bit_cnt_r + BIT_ONE;
                        if (bit_cnt_r == BIT_DATA_LAST) begin
                            state_nxt_s = HAS_PARITY ? RX_PARITY : RX_STOP;
                        end else begin
                            state_nxt_s = RX_DATA;
                        end
                    end else begin
                        bit_nxt_s = bit_cnt_r;
                    end
                end

                RX_PARITY: begin
                    samp_nxt_s = samp_inc_s;
                    if (decide_s) begin
                        par_err_nxt_s = bit_val_s ^ par_exp_s;
                    end else begin
                        par_err_nxt_s = par_err_r;
                    end
                    if (samp_last_s) begin
                        state_nxt_s = RX_STOP;
                    end else begin
                        state_nxt_s = RX_PARITY;
                    end
                end

                RX_STOP: begin
                    samp_nxt_s = samp_inc_s;
                    if (decide_s && (bit_cnt_r == BIT_STOP_LAST)) begin
                        // Leave mid-stop-bit so an immediate start is caught.
                        samp_nxt_s = SAMP_ZERO;
                        if (stop_err_r || !bit_val_s) begin
                            ferr_nxt_s  = 1'b1;
                            state_nxt_s = RX_WAIT_HIGH;
                        end else if (par_err_r) begin
                            perr_nxt_s  = 1'b1;
                            state_nxt_s = RX_IDLE;
                        end else begin
                            data_nxt_s  = shift_r;
                            valid_nxt_s = 1'b1;
                            state_nxt_s = RX_IDLE;
                        end
                    end else begin
                        if (decide_s) begin
                            stop_err_nxt_s = stop_err_r | ~bit_val_s;
                        end else begin
                            stop_err_nxt_s = stop_err_r;
                        end
                        if (samp_last_s) begin
                            bit_nxt_s = bit_cnt_r + BIT_ONE;
                        end else begin
                            bit_nxt_s = bit_cnt_r;
                        end
                    end
                end

                RX_WAIT_HIGH: begin
                    // A held-low line (break) must not restart frames.
                    samp_nxt_s = SAMP_ZERO;
                    if (line_s) begin
                        state_nxt_s = RX_IDLE;
                    end else begin
                        state_nxt_s = RX_WAIT_HIGH;
                    end
                end

                default: begin
                    state_nxt_s = RX_IDLE;
                    samp_nxt_s  = SAMP_ZERO;
                end
            endcase
        end else begin
            state_nxt_s = state_r;
        end
    end

    // State, counters, datapath and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r    <= RX_IDLE;
            samp_cnt_r <= SAMP_ZERO;
            bit_cnt_r  <= BIT_ZERO;
            shift_r    <= {DataBits{1'b0}};
            vote_r     <= 2'b00;
            par_err_r  <= 1'b0;
            stop_err_r <= 1'b0;
            data_r     <= {DataBits{1'b0}};
            valid_r    <= 1'b0;
            perr_r     <= 1'b0;
            ferr_r     <= 1'b0;
        end else begin
            state_r    <= state_nxt_s;
            samp_cnt_r <= samp_nxt_s;
            bit_cnt_r  <= bit_nxt_s;
            shift_r    <= shift_nxt_s;
            vote_r     <= vote_nxt_s;
            par_err_r  <= par_err_nxt_s;
            stop_err_r <= stop_err_nxt_s;
            data_r     <= data_nxt_s;
            valid_r    <= valid_nxt_s;
            perr_r     <= perr_nxt_s;
            ferr_r     <= ferr_nxt_s;
        end
    end

    assign data          = data_r;
    assign data_valid    = valid_r;
    assign parity_error  = perr_r;
    assign framing_error = ferr_r;

endmodule

// File: tb/tb_uart_rx_cfg.sv
// ----------------------------------------------------------------------------
// tb_uart_rx_cfg
// Directed bench for uart_rx_cfg with three instances: 8N1, 8E1 and 7O2,
// all at Oversample = 16. sample_trigger strobes every second clk; each line
// sample is held for exactly one trigger period.
// ----------------------------------------------------------------------------
module tb_uart_rx_cfg;
    import uart_pkg::*;

    localparam int OS = 16;

    logic clk = 1'b0;
    logic rst_n;
    logic trig;
    logic raw_a, raw_b, raw_c;

    logic [7:0] data_a, data_b;
    logic [6:0] data_c;
    logic dv_a, pe_a, fe_a;
    logic dv_b, pe_b, fe_b;
    logic dv_c, pe_c, fe_c;

    int n_checks = 0;
    int n_errors = 0;

    // Pulse bookkeeping, updated only by the monitor.
    int a_dv = 0, a_pe = 0, a_fe = 0;
    int b_dv = 0, b_pe = 0, b_fe = 0;
    int c_dv = 0, c_pe = 0, c_fe = 0;
    int multi = 0;
    logic [7:0] a_dat [0:7];

    // Latency measurement on instance A.
    logic sm1 = 1'b1, sm2 = 1'b1;
    int   tcount = 0;
    int   fall_idx = 0;
    int   lat = 0;
    bit   meas_arm = 1'b0;
    bit   meas_done = 1'b0;
    bit   lat_valid = 1'b0;

    always #5 clk = ~clk;

    uart_rx_cfg #(.DataBits(8), .Oversample(OS), .Parity(ParityNone), .StopBits(1)) u_8n1 (
        .clk(clk), .rst_n(rst_n), .sample_trigger(trig), .raw_data(raw_a),
        .data(data_a), .data_valid(dv_a), .parity_error(pe_a), .framing_error(fe_a));

    uart_rx_cfg #(.DataBits(8), .Oversample(OS), .Parity(ParityEven), .StopBits(1)) u_8e1 (
        .clk(clk), .rst_n(rst_n), .sample_trigger(trig), .raw_data(raw_b),
        .data(data_b), .data_valid(dv_b), .parity_error(pe_b), .framing_error(fe_b));

    uart_rx_cfg #(.DataBits(7), .Oversample(OS), .Parity(ParityOdd), .StopBits(2)) u_7o2 (
        .clk(clk), .rst_n(rst_n), .sample_trigger(trig), .raw_data(raw_c),
        .data(data_c), .data_valid(dv_c), .parity_error(pe_c), .framing_error(fe_c));

    // Trigger strobe: high for one clk out of every two.
    initial begin
        trig = 1'b0;
        forever begin
            @(negedge clk);
            trig = ~trig;
        end
    end

    // Pulse counters, data capture, one-hot watch and latency model.
    always @(posedge clk) begin
        if (!rst_n) begin
            sm1 <= 1'b1;
            sm2 <= 1'b1;
        end else begin
            sm1 <= raw_a;
            sm2 <= sm1;
        end
        if (trig) tcount <= tcount + 1;
        if (meas_arm && !meas_done && trig && !sm2) begin
            fall_idx  <= tcount;
            meas_done <= 1'b1;
        end
        if (dv_a) begin
            a_dat[a_dv[2:0]] <= data_a;
            a_dv <= a_dv + 1;
            if (meas_done && !lat_valid) begin
                lat       <= tcount - fall_idx;
                lat_valid <= 1'b1;
            end
        end
        if (pe_a) a_pe <= a_pe + 1;
        if (fe_a) a_fe <= a_fe + 1;
        if (dv_b) b_dv <= b_dv + 1;
        if (pe_b) b_pe <= b_pe + 1;
        if (fe_b) b_fe <= b_fe + 1;
        if (dv_c) c_dv <= c_dv + 1;
        if (pe_c) c_pe <= c_pe + 1;
        if (fe_c) c_fe <= c_fe + 1;
        if ((int'(dv_a) + int'(pe_a) + int'(fe_a) > 1) ||
            (int'(dv_b) + int'(pe_b) + int'(fe_b) > 1) ||
            (int'(dv_c) + int'(pe_c) + int'(fe_c) > 1))
            multi <= multi + 1;
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // One line sample, held for one trigger period (two clk).
    task automatic drive_sample(input int sel, input logic v);
        case (sel)
            0:       raw_a = v;
            1:       raw_b = v;
            default: raw_c = v;
        endcase
        repeat (2) @(negedge clk);
    endtask

    // One bit period; with corrupt set, every sample except C and C+1 is inverted.
    task automatic drive_bit(input int sel, input logic v, input bit corrupt);
        for (int k = 0; k < OS; k++) begin
            if (corrupt && !(k == OS/2 || k == OS/2 + 1))
                drive_sample(sel, ~v);
            else
                drive_sample(sel, v);
        end
    endtask

    task automatic idle_bits(input int sel, input int nbits);
        for (int k = 0; k < nbits; k++) drive_bit(sel, 1'b1, 1'b0);
    endtask

    task automatic send_frame(input int sel, input logic [8:0] payload, input int nbits,
                              input bit has_par, input logic par, input logic s0,
                              input logic s1, input int nstop, input bit corrupt);
        drive_bit(sel, 1'b0, 1'b0);
        for (int i = 0; i < nbits; i++) drive_bit(sel, payload[i], corrupt);
        if (has_par) drive_bit(sel, par, 1'b0);
        drive_bit(sel, s0, 1'b0);
        if (nstop == 2) drive_bit(sel, s1, 1'b0);
    endtask

    initial begin
        rst_n = 1'b0;
        raw_a = 1'b1;
        raw_b = 1'b1;
        raw_c = 1'b1;
        repeat (4) @(negedge clk);
        rst_n = 1'b1;
        drive_sample(0, 1'b1);

        // Reset state
        check_val("rst_data_a", 32'(data_a), 32'h0);
        check_val("rst_data_b", 32'(data_b), 32'h0);
        check_val("rst_data_c", 32'(data_c), 32'h0);
        check_val("rst_dv_a",   32'(dv_a),   32'h0);
        check_val("rst_pe_a",   32'(pe_a),   32'h0);
        check_val("rst_fe_a",   32'(fe_a),   32'h0);

        // 8N1 back-to-back 0xAB, 0xA3
        idle_bits(0, 1);
        meas_arm = 1'b1;
        send_frame(0, 9'h0AB, 8, 1'b0, 1'b0, 1'b1, 1'b1, 1, 1'b0);
        send_frame(0, 9'h0A3, 8, 1'b0, 1'b0, 1'b1, 1'b1, 1, 1'b0);
        idle_bits(0, 2);
        check_val("n1_dv_count", 32'(a_dv), 32'd2);
        check_val("n1_first",    32'(a_dat[0]), 32'hAB);
        check_val("n1_second",   32'(a_dat[1]), 32'hA3);
        check_val("n1_errs",     32'(a_pe + a_fe), 32'd0);
        check_val("n1_data_out", 32'(data_a), 32'hA3);
        check_val("n1_latency_valid", 32'(lat_valid), 32'd1);
        check_val("n1_latency", 32'(lat), 32'd154);

        // 8E1: good parity then bad parity
        idle_bits(1, 1);
        send_frame(1, 9'h0AB, 8, 1'b1, 1'b1, 1'b1, 1'b1, 1, 1'b0);
        idle_bits(1, 2);
        check_val("e1_dv_count", 32'(b_dv), 32'd1);
        check_val("e1_data",     32'(data_b), 32'hAB);
        send_frame(1, 9'h0AB, 8, 1'b1, 1'b0, 1'b1, 1'b1, 1, 1'b0);
        idle_bits(1, 2);
        check_val("e1_pe_count", 32'(b_pe), 32'd1);
        check_val("e1_dv_after_pe", 32'(b_dv), 32'd1);
        check_val("e1_data_kept", 32'(data_b), 32'hAB);
        check_val("e1_fe_count", 32'(b_fe), 32'd0);

        // 7O2: second stop low, line break, then a good frame
        idle_bits(2, 1);
        send_frame(2, 9'h03C, 7, 1'b1, 1'b1, 1'b1, 1'b0, 2, 1'b0);
        check_val("o2_fe_count", 32'(c_fe), 32'd1);
        for (int k = 0; k < 40; k++) drive_bit(2, 1'b0, 1'b0);
        check_val("o2_break_quiet", 32'(c_fe + c_pe + c_dv), 32'd1);
        idle_bits(2, 2);
        send_frame(2, 9'h03C, 7, 1'b1, 1'b1, 1'b1, 1'b1, 2, 1'b0);
        idle_bits(2, 2);
        check_val("o2_dv_count", 32'(c_dv), 32'd1);
        check_val("o2_data",     32'(data_c), 32'h3C);
        check_val("o2_pe_count", 32'(c_pe), 32'd0);

        // False start: 3 low samples, then 0x55
        for (int k = 0; k < 3; k++) drive_sample(0, 1'b0);
        idle_bits(0, 2);
        check_val("fs_quiet", 32'(a_dv + a_pe + a_fe), 32'd2);
        send_frame(0, 9'h055, 8, 1'b0, 1'b0, 1'b1, 1'b1, 1, 1'b0);
        idle_bits(0, 2);
        check_val("fs_dv_count", 32'(a_dv), 32'd3);
        check_val("fs_data",     32'(data_a), 32'h55);

        // Majority vote recovers 0xAB from corrupted bit periods
        send_frame(0, 9'h0AB, 8, 1'b0, 1'b0, 1'b1, 1'b1, 1, 1'b1);
        idle_bits(0, 2);
        check_val("mv_dv_count", 32'(a_dv), 32'd4);
        check_val("mv_data",     32'(data_a), 32'hAB);

        // Reset during data bit 4, then 0x96
        drive_bit(0, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) drive_bit(0, 1'b1, 1'b0);
        for (int k = 0; k < OS/2; k++) drive_sample(0, 1'b0);
        rst_n = 1'b0;
        drive_sample(0, 1'b1);
        drive_sample(0, 1'b1);
        check_val("mr_data", 32'(data_a), 32'h0);
        check_val("mr_outs", 32'({dv_a, pe_a, fe_a}), 32'h0);
        rst_n = 1'b1;
        idle_bits(0, 2);
        check_val("mr_no_pulse", 32'(a_dv + a_pe + a_fe), 32'd4);
        send_frame(0, 9'h096, 8, 1'b0, 1'b0, 1'b1, 1'b1, 1, 1'b0);
        idle_bits(0, 2);
        check_val("mr_dv_count", 32'(a_dv), 32'd5);
        check_val("mr_data_new", 32'(data_a), 32'h96);

        check_val("pulse_onehot", 32'(multi), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/uart_rx_cfg.md
# uart_rx_cfg

Parametrised oversampling UART receiver, successor to the fixed 8N1 receiver. Data width, parity mode, stop-bit count and oversampling ratio are configurable. Each bit is decided by a 3-sample majority vote, and framing and parity errors are reported separately. It sits between the pad-side serial input and the byte-stream consumer, and is paced by an external `pulse_generator` strobe at Oversample × baud.

## Interface
- `DataBits`, 8: payload bits per frame, 5..9, LSB first on the line.
- `Oversample`, 16: `sample_trigger` strobes per bit period, even, ≥ 4.
- `Parity`, `ParityNone`: `uart_pkg::parity_e`, one of `ParityNone`, `ParityEven`, `ParityOdd`.
- `StopBits`, 1: 1 or 2.

- `clk`  in  1  system clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `sample_trigger`  in  1  one-`clk` strobe, Oversample per bit period.
- `raw_data`  in  1  asynchronous serial line, idle high.
- `data`  out  DataBits  last good payload; held until the next good frame.
- `data_valid`  out  1  one-`clk` pulse, `data` is new.
- `parity_error`  out  1  one-`clk` pulse, parity mismatch, frame discarded.
- `framing_error`  out  1  one-`clk` pulse, a stop bit sampled low, frame discarded.

## Operation
- `raw_data` passes through a 2-flop synchronizer on `clk`. All other logic uses only the synchronized line.
- FSM state and counters advance only on `clk` edges where `sample_trigger` = 1.
- FSM states are IDLE, START, DATA, PARITY, STOP, WAIT_HIGH.
  - PARITY is skipped when `Parity` = `ParityNone`.
- `samp_cnt` counts 0..Oversample-1 within each bit. `bit_cnt` counts data bits, then stop bits.
- Let C = Oversample/2. The bit value is the majority of the samples at indices C-1, C and C+1, decided at index C+1.
- IDLE: a low sample starts the frame. That sample is index 0 of START.
- START: if the vote at index C+1 is 1, the start was false. Return to IDLE with no output.
- DATA: shift the voted bit in LSB first. After DataBits bits, go to PARITY or STOP.
- PARITY: expected bit = XOR of the payload (`ParityEven`), or its inverse (`ParityOdd`). A mismatch is latched, not reported yet.
- STOP: every stop bit is voted. Results are reported at the decision point of the last stop bit, in this priority:
  1. Any stop bit voted 0: pulse `framing_error`, go to WAIT_HIGH.
  2. Else parity mismatch latched: pulse `parity_error`, go to IDLE.
  3. Else update `data`, pulse `data_valid`, go to IDLE.
- Return to IDLE happens mid-stop-bit, so a start bit following immediately is caught.
- WAIT_HIGH: stay until one sample is high, then go to IDLE. This prevents a line break from retriggering frames.
- A discarded frame never modifies `data`.
- At most one of the three pulse outputs is high in any cycle.

## Timing
- On reset, `data`, `data_valid`, `parity_error` and `framing_error` are 0, the FSM is IDLE, the counters are 0, and the synchronizer flops are 1.
- Reset mid-frame abandons the frame silently, with no pulse.
- Input latency is 2 `clk` through the synchronizer.
- Outputs are registered. Pulses assert on the `clk` after the `sample_trigger` edge at the final decision point, and last exactly one `clk`.
- A perfect frame is reported (1 + DataBits + P + StopBits - 1) × Oversample + C + 2 triggers after the start-bit falling sample, where P = 1 with parity and 0 without. Add the synchronizer latency on top.
- `sample_trigger` held high continuously is legal: the block then samples every `clk`.

## Structure
- The shared package `uart_pkg` holds `parity_e` and the FSM state enum `rx_state_e`. The sibling transmitter reuses `parity_e`.
- The natural sub-module is `sync_2ff`, a 2-flop synchronizer with reset value 1. Counters, vote and FSM stay in one module.
- Counter widths are $clog2(Oversample) and $clog2(DataBits + StopBits + 1).

## Test plan
- 8N1, Oversample = 16, send 0xAB then 0xA3 back-to-back → `data_valid` ×2 with `data` = 0xAB, then 0xA3; no error pulses.
- 8E1, send 0xAB with parity bit 1 → `data_valid`, `data` = 0xAB. Repeat with parity bit 0 → one `parity_error`, no `data_valid`, `data` stays 0xAB.
- 7O2, second stop bit low on payload 0x3C → one `framing_error`. Hold the line low for 40 bit times → no further pulses. Release, then send 0x3C with good parity → `data_valid`, `data` = 0x3C.
- Line low for 3 samples, then high → no output. Next frame 0x55 → `data` = 0x55.
- Each bit of 0xAB has sample C-1 inverted and everything outside C-1..C+1 corrupted → majority vote recovers `data` = 0xAB.
- Pull `rst_n` low during data bit 4, then release → all outputs 0, no pulse. Next frame 0x96 → `data` = 0x96.
